// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared types, defaults and sizing helper for the round-robin mux arbiter
package mux_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_N_REQ    = 16;
    localparam int DEF_SEL_W    = sel_w(DEF_N_REQ);
    localparam int DEF_MAX_HOLD = 8;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: masked round-robin priority encoder, first set bit at or above ptr (wrapping)
module rr_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic [W-1:0] mask_idx,
    input  logic         mask_en,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    // Scan from farthest to nearest so the closest eligible index to ptr wins last
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            cand = ptr + W'(i);
            if (req[cand] && !(mask_en && cand == mask_idx)) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter with bounded tenure driving a shared N_REQ:1 mux
// Optional: define ARB_LOCK_EN to add a lock input that blocks preemption of the holder.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int SEL_W    = sel_w(N_REQ),
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
`ifdef ARB_LOCK_EN
    input  logic             lock,
`endif
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             gnt_vld
);

    localparam bit HOLD_EN = MAX_HOLD != 0;
    localparam logic [HOLD_W-1:0] HOLD_SAT = (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic               in_grant, others, no_lock, preempt, stay, found;
    logic [SEL_W-1:0]   win;

`ifdef ARB_LOCK_EN
    assign no_lock = !lock;
`else
    assign no_lock = 1'b1;
`endif

    assign in_grant = state_q == GRANT;
    assign others   = |(req & ~(N_REQ'(1) << sel_q));
    assign preempt  = HOLD_EN && hold_q == HOLD_SAT && others && no_lock;
    assign stay     = in_grant && req[sel_q] && !preempt;

    // The current holder is excluded whenever we arbitrate out of GRANT (release or preempt)
    rr_pick #(.N(N_REQ), .W(SEL_W)) u_pick (
        .req      (req),
        .ptr      (ptr_q),
        .mask_idx (sel_q),
        .mask_en  (in_grant),
        .found    (found),
        .idx      (win)
    );

    // Next-state: keep the holder, hand over to a new winner, or fall idle
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        if (stay) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
        end else if (found) begin
            state_d   = GRANT;
            sel_d     = win;
            gnt_d     = N_REQ'(1) << win;
            gnt_vld_d = 1'b1;
            ptr_d     = win + SEL_W'(1);
            hold_d    = '0;
        end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_vld_d = 1'b0;
            hold_d    = '0;
        end
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            hold_q    <= '0;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign gnt_vld = gnt_vld_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: vector table, directed corner sequences and randomized model comparison
module tb_mux_rr_arbiter;

    localparam int N        = 16;
    localparam int MAX_HOLD = 8;
    localparam int SAT      = (MAX_HOLD == 0) ? 15 : MAX_HOLD - 1;

    typedef struct {
        logic [15:0] req;
        logic [15:0] gnt;
        logic [3:0]  sel;
        logic        vld;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] req = '0;
    logic        lock = 1'b0;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        gnt_vld;

    int checks = 0;
    int failures = 0;

    int m_idx, m_ptr, m_cnt, m_sel;

    vec_t tbl[12];

    always #5 clk = ~clk;

    mux_rr_arbiter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
`ifdef ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .sel     (sel),
        .gnt_vld (gnt_vld)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [15:0] r, input int from, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (from + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_idx = -1;
        m_ptr = 0;
        m_cnt = 0;
        m_sel = 0;
    endtask

    task automatic m_grant(input int w);
        m_idx = w;
        m_sel = w;
        m_ptr = (w + 1) % N;
        m_cnt = 0;
    endtask

    // Reference behaviour at one clock edge, from the arbitration rules
    task automatic m_step(input logic [15:0] r, input logic lk);
        int w;
        if (m_idx >= 0 && r[m_idx]) begin
            if (MAX_HOLD != 0 && m_cnt == MAX_HOLD - 1 && (r & ~(16'(1) << m_idx)) != 0 && !lk) begin
                m_grant(pick(r, m_ptr, m_idx));
            end else if (m_cnt < SAT) begin
                m_cnt++;
            end
        end else begin
            w = pick(r, m_ptr, m_idx);
            if (w >= 0) m_grant(w);
            else begin
                m_idx = -1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step(input logic [15:0] r);
        logic lk;
        req = r;
`ifdef ARB_LOCK_EN
        lk = lock;
`else
        lk = 1'b0;
`endif
        @(posedge clk);
        m_step(r, lk);
        #1;
        check("model_gnt", gnt, (m_idx >= 0) ? (16'(1) << m_idx) : 16'h0);
        check("model_vld", gnt_vld, m_idx >= 0);
        check("model_sel", sel, m_sel);
    endtask

    initial begin
        tbl[0]  = '{16'h8081, 16'h0001, 4'd0,  1'b1};
        tbl[1]  = '{16'h8080, 16'h0080, 4'd7,  1'b1};
        tbl[2]  = '{16'h8001, 16'h8000, 4'd15, 1'b1};
        tbl[3]  = '{16'h0081, 16'h0001, 4'd0,  1'b1};
        tbl[4]  = '{16'h0000, 16'h0000, 4'd0,  1'b0};
        tbl[5]  = '{16'h0001, 16'h0001, 4'd0,  1'b1};
        tbl[6]  = '{16'h0000, 16'h0000, 4'd0,  1'b0};
        tbl[7]  = '{16'h0008, 16'h0008, 4'd3,  1'b1};
        tbl[8]  = '{16'h0200, 16'h0200, 4'd9,  1'b1};
        tbl[9]  = '{16'h0000, 16'h0000, 4'd9,  1'b0};
        tbl[10] = '{16'h0010, 16'h0010, 4'd4,  1'b1};
        tbl[11] = '{16'h0000, 16'h0000, 4'd4,  1'b0};

        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_gnt", gnt, 16'h0);
        check("reset_sel", sel, 4'd0);
        check("reset_vld", gnt_vld, 1'b0);
        rst_n = 1'b1;

        // Wrap order, single grant/drop, release with same-edge handover
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].req);
            check($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            check($sformatf("tbl%0d_sel", i), sel, tbl[i].sel);
            check($sformatf("tbl%0d_vld", i), gnt_vld, tbl[i].vld);
        end

        // Two contenders alternate every MAX_HOLD cycles
        for (int c = 0; c < 24; c++) begin
            step(16'h0006);
            check($sformatf("alt%0d_sel", c), sel, ((c / 8) % 2) ? 4'd2 : 4'd1);
        end
        step(16'h0000);

        // Lone holder keeps the grant; counter saturates so a newcomer preempts at once
        for (int c = 0; c < 20; c++) begin
            step(16'h0020);
            check($sformatf("solo%0d_sel", c), sel, 4'd5);
            check($sformatf("solo%0d_vld", c), gnt_vld, 1'b1);
        end
        step(16'h0060);
        check("sat_preempt_sel", sel, 4'd6);

        // Asynchronous reset in the middle of a grant
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check("async_rst_gnt", gnt, 16'h0);
        check("async_rst_vld", gnt_vld, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(16'hFFFF);
        check("post_rst_sel", sel, 4'd0);
        check("post_rst_vld", gnt_vld, 1'b1);
        step(16'h0000);

`ifdef ARB_LOCK_EN
        lock = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(16'h0006);
            check($sformatf("lock%0d_sel", c), sel, 4'd1);
        end
        step(16'h0004);
        check("lock_release_sel", sel, 4'd2);
        lock = 1'b0;
        step(16'h0000);
`endif

        // Randomized traffic against the reference model
        for (int c = 0; c < 800; c++) begin
            logic [15:0] r;
            r = req;
            if ($urandom_range(0, 7) == 0) r = 16'($urandom) & 16'($urandom);
            else if ($urandom_range(0, 2) == 0) r[$urandom_range(0, 15)] ^= 1'b1;
`ifdef ARB_LOCK_EN
            if ($urandom_range(0, 15) == 0) lock = ~lock;
`endif
            step(r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
